axi_sram_slave: RTL and testbench

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

---
 rtl/axi_sram_pkg.sv | 15 +
 rtl/axi4_interface.sv | 43 ++++
 rtl/sram_1r1w.sv | 30 +++
 rtl/axi_sram_slave.sv | 191 +++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_sram_pkg.sv
// Shared definitions for the AXI SRAM slave: FSM state encoding and burst-length widths.
package axi_sram_pkg;

    localparam int unsigned AXI_LEN_W  = 8;
    localparam int unsigned BEAT_CNT_W = AXI_LEN_W + 1;
    localparam int unsigned RBUF_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WRITE_BURST = 2'd1,
        WRITE_RESP  = 2'd2,
        READ_BURST  = 2'd3
    } axi_sram_state_t;

endpackage

// File: rtl/axi4_interface.sv
// Master side of the async AXI bridge as seen by the SRAM slave (m_* from bridge, s_* from slave).
interface axi4_interface #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    import axi_sram_pkg::*;

    logic [ADDR_WIDTH-1:0] m_awaddr;
    logic [AXI_LEN_W-1:0]  m_awlen;
    logic                  m_awvalid;
    logic                  s_awready;

    logic [DATA_WIDTH-1:0] m_wdata;
    logic                  m_wlast;
    logic                  m_wvalid;
    logic                  s_wready;

    logic                  s_bvalid;
    logic                  m_bready;

    logic [ADDR_WIDTH-1:0] m_araddr;
    logic [AXI_LEN_W-1:0]  m_arlen;
    logic                  m_arvalid;
    logic                  s_arready;

    logic [DATA_WIDTH-1:0] s_rdata;
    logic                  s_rvalid;
    logic                  m_rready;

    modport slave (
        input  m_awaddr, m_awlen, m_awvalid,
        output s_awready,
        input  m_wdata, m_wlast, m_wvalid,
        output s_wready,
        output s_bvalid,
        input  m_bready,
        input  m_araddr, m_arlen, m_arvalid,
        output s_arready,
        output s_rdata, s_rvalid,
        input  m_rready
    );

endinterface

// File: rtl/sram_1r1w.sv
// Single-port-pair SRAM: one synchronous write and one 1-cycle-latency synchronous read per clock.
module sram_1r1w #(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned MEM_WORDS  = 4096,
    localparam int unsigned IDX_W      = $clog2(MEM_WORDS)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 INCR-burst slave in front of a 1R1W SRAM; reads stream through a 2-entry output buffer
// with the first SRAM read launched in the AR-handshake cycle to hit 2-cycle read latency.
module axi_sram_slave
    import axi_sram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_WORDS  = 4096
) (
    input  logic          clk,
    input  logic          reset_n,
    axi4_interface.slave  axi_bus
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);

    axi_sram_state_t       state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [AXI_LEN_W-1:0]  len_q, len_d;
    logic [BEAT_CNT_W-1:0] beat_q, beat_d;
    logic [BEAT_CNT_W-1:0] iss_q, iss_d;
    logic                  wr_pri_q, wr_pri_d;
    logic                  pend_q, pend_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;

    logic                  aw_ready_c, ar_ready_c;
    logic                  grant_wr_c, grant_rd_c, both_c, pop_c;
    logic                  mem_we_c, mem_re_c;
    logic [IDX_W-1:0]      mem_raddr_c, aw_idx_c, ar_idx_c;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  unused_wlast;

    assign aw_idx_c     = IDX_W'(ADDR_WIDTH'(axi_bus.m_awaddr) >> 2);
    assign ar_idx_c     = IDX_W'(ADDR_WIDTH'(axi_bus.m_araddr) >> 2);
    assign unused_wlast = axi_bus.m_wlast;

    sram_1r1w #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS)
    ) u_sram (
        .clk     (clk),
        .we_i    (mem_we_c),
        .waddr_i (idx_q),
        .wdata_i (axi_bus.m_wdata),
        .re_i    (mem_re_c),
        .raddr_i (mem_raddr_c),
        .rdata_o (mem_rdata)
    );

    // Next-state, SRAM control and read-buffer update.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        beat_d      = beat_q;
        iss_d       = iss_q;
        wr_pri_d    = wr_pri_q;
        cnt_d       = cnt_q;
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        aw_ready_c  = 1'b0;
        ar_ready_c  = 1'b0;
        grant_wr_c  = 1'b0;
        grant_rd_c  = 1'b0;
        mem_we_c    = 1'b0;
        mem_re_c    = 1'b0;
        mem_raddr_c = idx_q;
        both_c      = axi_bus.m_awvalid && axi_bus.m_arvalid;
        pop_c       = (cnt_q != 2'd0) && axi_bus.m_rready;

        unique case (state_q)
            IDLE: begin
                aw_ready_c = reset_n && !(both_c && !wr_pri_q);
                ar_ready_c = reset_n && !(both_c && wr_pri_q);
                grant_wr_c = axi_bus.m_awvalid && aw_ready_c;
                grant_rd_c = axi_bus.m_arvalid && ar_ready_c;
                if (grant_wr_c) begin
                    state_d  = WRITE_BURST;
                    idx_d    = aw_idx_c;
                    len_d    = axi_bus.m_awlen;
                    beat_d   = '0;
                    wr_pri_d = 1'b0;
                end else if (grant_rd_c) begin
                    // Launch beat 0 now so data lands in the buffer two cycles after AR.
                    state_d     = READ_BURST;
                    len_d       = axi_bus.m_arlen;
                    beat_d      = '0;
                    mem_re_c    = 1'b1;
                    mem_raddr_c = ar_idx_c;
                    idx_d       = ar_idx_c + IDX_W'(1);
                    iss_d       = BEAT_CNT_W'(1);
                    wr_pri_d    = 1'b1;
                end
            end
            WRITE_BURST: begin
                if (axi_bus.m_wvalid) begin
                    mem_we_c = 1'b1;
                    idx_d    = idx_q + IDX_W'(1);
                    if (beat_q == BEAT_CNT_W'(len_q)) begin
                        state_d = WRITE_RESP;
                    end else begin
                        beat_d = beat_q + BEAT_CNT_W'(1);
                    end
                end
            end
            WRITE_RESP: begin
                if (axi_bus.m_bready) begin
                    state_d = IDLE;
                end
            end
            READ_BURST: begin
                // Occupancy plus in-flight read must stay within the buffer after this cycle.
                if ((iss_q <= BEAT_CNT_W'(len_q)) &&
                    ((3'(cnt_q) + 3'(pend_q)) < (3'(RBUF_DEPTH) + 3'(pop_c)))) begin
                    mem_re_c = 1'b1;
                    idx_d    = idx_q + IDX_W'(1);
                    iss_d    = iss_q + BEAT_CNT_W'(1);
                end
                if (pop_c) begin
                    if (beat_q == BEAT_CNT_W'(len_q)) begin
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        pend_d = mem_re_c;

        unique case ({pend_q, pop_c})
            2'b01: begin
                buf0_d = buf1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    buf0_d = mem_rdata;
                end else begin
                    buf1_d = mem_rdata;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    buf0_d = mem_rdata;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            iss_q    <= '0;
            wr_pri_q <= 1'b0;
            pend_q   <= 1'b0;
            cnt_q    <= 2'd0;
            buf0_q   <= '0;
            buf1_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            iss_q    <= iss_d;
            wr_pri_q <= wr_pri_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            buf0_q   <= buf0_d;
            buf1_q   <= buf1_d;
        end
    end

    assign axi_bus.s_awready = aw_ready_c;
    assign axi_bus.s_arready = ar_ready_c;
    assign axi_bus.s_wready  = (state_q == WRITE_BURST);
    assign axi_bus.s_bvalid  = (state_q == WRITE_RESP);
    assign axi_bus.s_rvalid  = (cnt_q != 2'd0);
    assign axi_bus.s_rdata   = buf0_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave on a 16-word SRAM so address wrap is reachable.
module tb_axi_sram_slave;

    logic clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] wbuf [16];
    logic [31:0] rexp [16];

    axi4_interface #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi_sram_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_WORDS  (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .axi_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic aw_issue(input logic [31:0] addr, input logic [7:0] len);
        bus.m_awaddr  = addr;
        bus.m_awlen   = len;
        bus.m_awvalid = 1'b1;
        #1 check("aw_ready", 32'(bus.s_awready), 32'd1);
        @(negedge clk);
        bus.m_awvalid = 1'b0;
    endtask

    task automatic ar_issue(input logic [31:0] addr, input logic [7:0] len);
        bus.m_araddr  = addr;
        bus.m_arlen   = len;
        bus.m_arvalid = 1'b1;
        #1 check("ar_ready", 32'(bus.s_arready), 32'd1);
        @(negedge clk);
        bus.m_arvalid = 1'b0;
    endtask

    task automatic w_beats(input int len);
        for (int i = 0; i <= len; i++) begin
            bus.m_wdata  = wbuf[i];
            bus.m_wvalid = 1'b1;
            bus.m_wlast  = (i == len);
            #1 check("w_ready", 32'(bus.s_wready), 32'd1);
            @(negedge clk);
        end
        bus.m_wvalid = 1'b0;
        bus.m_wlast  = 1'b0;
    endtask

    task automatic b_resp();
        #1 check("b_valid", 32'(bus.s_bvalid), 32'd1);
        bus.m_bready = 1'b1;
        @(negedge clk);
        bus.m_bready = 1'b0;
        #1 check("b_valid_clr", 32'(bus.s_bvalid), 32'd0);
        check("b_aw_ready", 32'(bus.s_awready), 32'd1);
    endtask

    task automatic write_burst(input logic [31:0] addr, input int len);
        aw_issue(addr, 8'(len));
        w_beats(len);
        b_resp();
    endtask

    // Collect len+1 read beats; bp selects the 1,0,0,1 ready pattern, chk compares against rexp.
    task automatic r_collect(input int len, input bit bp, input bit chk);
        int          got = 0;
        int          k = 0;
        int          first = -1;
        int          last = -1;
        bit          prev_stall = 1'b0;
        logic [31:0] prev_data = '0;
        while (got <= len && k < 64) begin
            bus.m_rready = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            #1;
            if (prev_stall) begin
                check("r_hold_valid", 32'(bus.s_rvalid), 32'd1);
                check("r_hold_data", bus.s_rdata, prev_data);
            end
            if (bus.s_rvalid) begin
                if (first < 0) first = k;
                if (bus.m_rready) begin
                    if (chk) check($sformatf("r_data%0d", got), bus.s_rdata, rexp[got]);
                    got++;
                    last = k;
                end
            end
            prev_stall = bus.s_rvalid && !bus.m_rready;
            prev_data  = bus.s_rdata;
            @(negedge clk);
            k++;
        end
        bus.m_rready = 1'b0;
        check("r_beats", got, len + 1);
        if (!bp) begin
            check("r_first_lat", first, 1);
            check("r_span", last - first, len);
        end
        #1 check("r_idle_rvalid", 32'(bus.s_rvalid), 32'd0);
        check("r_idle_arready", 32'(bus.s_arready), 32'd1);
    endtask

    task automatic read_burst(input logic [31:0] addr, input int len, input bit bp);
        ar_issue(addr, 8'(len));
        r_collect(len, bp, 1'b1);
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.m_awaddr  = '0;
        bus.m_awlen   = '0;
        bus.m_awvalid = 1'b0;
        bus.m_wdata   = '0;
        bus.m_wlast   = 1'b0;
        bus.m_wvalid  = 1'b0;
        bus.m_bready  = 1'b0;
        bus.m_araddr  = '0;
        bus.m_arlen   = '0;
        bus.m_arvalid = 1'b0;
        bus.m_rready  = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_awready", 32'(bus.s_awready), 32'd0);
        check("rst_arready", 32'(bus.s_arready), 32'd0);
        check("rst_rvalid", 32'(bus.s_rvalid), 32'd0);
        check("rst_bvalid", 32'(bus.s_bvalid), 32'd0);
        check("rst_wready", 32'(bus.s_wready), 32'd0);
        reset_n = 1'b1;
        #1;
        check("rel_awready", 32'(bus.s_awready), 32'd1);
        check("rel_arready", 32'(bus.s_arready), 32'd1);
        @(negedge clk);

        // First conflict after reset goes to the read, second to the write.
        bus.m_awaddr  = 32'h20;
        bus.m_awlen   = 8'd0;
        bus.m_araddr  = 32'h10;
        bus.m_arlen   = 8'd0;
        bus.m_awvalid = 1'b1;
        bus.m_arvalid = 1'b1;
        #1;
        check("cf1_arready", 32'(bus.s_arready), 32'd1);
        check("cf1_awready", 32'(bus.s_awready), 32'd0);
        @(negedge clk);
        bus.m_arvalid = 1'b0;
        #1 check("cf1_busy_awready", 32'(bus.s_awready), 32'd0);
        r_collect(0, 1'b0, 1'b0);
        bus.m_arvalid = 1'b1;
        #1;
        check("cf2_awready", 32'(bus.s_awready), 32'd1);
        check("cf2_arready", 32'(bus.s_arready), 32'd0);
        @(negedge clk);
        bus.m_awvalid = 1'b0;
        bus.m_arvalid = 1'b0;
        wbuf[0] = 32'h0000_0055;
        w_beats(0);
        b_resp();
        rexp[0] = 32'h0000_0055;
        read_burst(32'h20, 0, 1'b0);

        // Single write then single read.
        wbuf[0] = 32'hDEAD_BEEF;
        write_burst(32'h10, 0);
        rexp[0] = 32'hDEAD_BEEF;
        read_burst(32'h10, 0, 1'b0);

        // 8-beat burst, streamed back at full rate.
        for (int i = 0; i < 8; i++) begin
            wbuf[i] = 32'(i + 1);
            rexp[i] = 32'(i + 1);
        end
        write_burst(32'h100, 7);
        read_burst(32'h100, 7, 1'b0);

        // Back-pressured 4-beat read of the same words.
        read_burst(32'h100, 3, 1'b1);

        // Wrap: index 15 then index 0.
        wbuf[0] = 32'hAAAA_0001;
        wbuf[1] = 32'hBBBB_0002;
        write_burst(32'h3C, 1);
        rexp[0] = 32'hAAAA_0001;
        rexp[1] = 32'hBBBB_0002;
        read_burst(32'h3C, 1, 1'b0);
        rexp[0] = 32'hBBBB_0002;
        read_burst(32'h00, 0, 1'b0);
        rexp[0] = 32'hAAAA_0001;
        read_burst(32'h3C, 0, 1'b0);

        // Preload indices 10..13, then reset after two beats of an overwrite.
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h11 * 32'(i + 1);
        write_burst(32'h28, 3);
        @(negedge clk);
        aw_issue(32'h28, 8'd3);
        wbuf[0] = 32'hA1;
        wbuf[1] = 32'hA2;
        w_beats(1);
        reset_n = 1'b0;
        #1 check("mid_rst_awready", 32'(bus.s_awready), 32'd0);
        @(negedge clk);
        #1;
        check("mid_rst_awready2", 32'(bus.s_awready), 32'd0);
        check("mid_rst_bvalid", 32'(bus.s_bvalid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 check("mid_rel_awready", 32'(bus.s_awready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 check("mid_no_bvalid", 32'(bus.s_bvalid), 32'd0);
        end
        @(negedge clk);
        rexp[0] = 32'hA1;
        rexp[1] = 32'hA2;
        rexp[2] = 32'h33;
        rexp[3] = 32'h44;
        read_burst(32'h28, 3, 1'b0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
